// File: rtl/prbs_checker.sv
// Self-synchronising checker for the x^8+x^6+x^5+x^4+1 PRBS stream (MSB-first generator).
// Optional saturating error counter and its clear are built only when PRBS_CHK_ERRCNT_EN is defined.
module prbs_checker #(
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  input  logic        clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  typedef enum logic {SEARCH, LOCKED} state_e;

  localparam logic [7:0] WIN_LAST  = 8'(WINDOW);
  localparam logic [7:0] LOSS_LIM  = 8'(LOSS_THRESH);
  localparam logic [3:0] FILL_FULL = 4'd8;

  state_e      state_q, state_d;
  logic [7:0]  r_q, r_d;
  logic [3:0]  fill_q, fill_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [7:0]  win_err_q, win_err_d;
  logic        err_pulse_q, err_pulse_d;

  logic        fb;
  logic        mismatch;
  logic [7:0]  r_shift_din;
  logic [3:0]  fill_inc;
  logic [7:0]  win_cnt_inc;
  logic [7:0]  win_err_inc;

  assign fb          = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
  assign mismatch    = en && (state_q == LOCKED) && (din != fb);
  assign r_shift_din = {r_q[6:0], din};
  assign fill_inc    = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
  assign win_cnt_inc = win_cnt_q + 8'd1;
  assign win_err_inc = win_err_q + {7'd0, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      r_q         <= '0;
      fill_q      <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = mismatch;
    if (en) begin
      case (state_q)
        SEARCH: begin
          r_d    = r_shift_din;
          fill_d = fill_inc;
          if ((fill_inc == FILL_FULL) && (r_shift_din != '0)) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          // Predicted bit is shifted in so one corrupted bit yields exactly one error.
          r_d = {r_q[6:0], fb};
          if (win_err_inc == LOSS_LIM) begin
            state_d   = SEARCH;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_inc == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_inc;
            win_err_d = win_err_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked    = (state_q == LOCKED);
    err_pulse = err_pulse_q;
  end

`ifdef PRBS_CHK_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (clr) begin
      err_count_d = '0;
    end else if (mismatch && (err_count_q != '1)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: an MSB-first LFSR source with bit inversion drives the main
// instance; a second instance with a 255/255 window is driven to exercise long error runs.
module tb_prbs_checker;

  localparam int unsigned WIN  = 64;
  localparam int unsigned LOSS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, din = 1'b0, clr = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        rst2 = 1'b1, en2 = 1'b0, din2 = 1'b0, clr2 = 1'b0;
  logic        locked2, err_pulse2;
  logic [15:0] err_count2;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned nstep    = 0;

  always #5 clk = ~clk;

  prbs_checker #(.WINDOW(WIN), .LOSS_THRESH(LOSS)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs_checker #(.WINDOW(255), .LOSS_THRESH(255)) u_sat (
    .clk(clk), .rst(rst2), .en(en2), .din(din2), .clr(clr2),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2)
  );

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Expected-behaviour tracker: a mismatch is expected exactly where the bench inverted a bit.
  bit          m_locked = 1'b0;
  bit          m_pulse  = 1'b0;
  int unsigned m_fill = 0, m_win = 0, m_werr = 0;
  logic [7:0]  m_hist = '0;
  logic [15:0] m_cnt  = '0;
  logic [7:0]  g      = 8'hD3;

  logic [7:0]  sh = '0;
  int unsigned ph = 0;

  function automatic logic [15:0] ec(input logic [15:0] v);
`ifdef PRBS_CHK_ERRCNT_EN
    return v;
`else
    return (v & 16'h0000);
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, nstep, obs, exp);
    end
  endtask

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("locked", {15'd0, locked}, {15'd0, e.lk});
      chk("err_pulse", {15'd0, err_pulse}, {15'd0, e.ep});
      chk("err_count", err_count, e.cnt);
    end
  endtask

  function automatic logic gen_next();
    logic o;
    o = g[7];
    g = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[3]};
    return o;
  endfunction

  task automatic step(input bit r, input bit e, input bit inj, input bit c);
    @(negedge clk);
    compare_pop();
    nstep++;
    rst = r;
    en  = e;
    clr = c;
    if (e) din = gen_next() ^ inj;
    else   din = 1'($urandom_range(0, 1));
    if (r) begin
      m_locked = 1'b0; m_pulse = 1'b0; m_fill = 0; m_win = 0; m_werr = 0;
      m_hist = '0; m_cnt = '0;
    end else begin
      m_pulse = 1'b0;
      if (e) begin
        if (!m_locked) begin
          m_hist = {m_hist[6:0], din};
          if (m_fill < 8) m_fill++;
          if (m_fill == 8 && m_hist != 8'h00) m_locked = 1'b1;
        end else begin
          m_pulse = inj;
          m_win++;
          if (inj) m_werr++;
          if (m_werr == LOSS) begin
            m_locked = 1'b0; m_fill = 0; m_win = 0; m_werr = 0;
          end else if (m_win == WIN) begin
            m_win = 0; m_werr = 0;
          end
        end
      end
      if (c) m_cnt = '0;
      else if (m_pulse && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    exp_q.push_back('{lk: m_locked, ep: m_pulse, cnt: ec(m_cnt)});
  endtask

  // Drives u_sat so that every compared bit is the complement of its prediction.
  task automatic sat_bit();
    logic p;
    @(negedge clk);
    en2 = 1'b1;
    if (ph < 8) begin
      din2 = 1'b1;
      sh   = {sh[6:0], 1'b1};
    end else begin
      p    = sh[7] ^ sh[5] ^ sh[4] ^ sh[3];
      din2 = ~p;
      sh   = {sh[6:0], p};
    end
    ph = (ph == 262) ? 0 : ph + 1;
  endtask

  task automatic sat_pause();
    @(negedge clk);
    en2 = 1'b0;
  endtask

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Clean lock, single inverted 20th bit, long clean run.
    for (int i = 1; i <= 19; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    repeat (520) step(0, 1, 0, 0);

    // Error followed by a gap, then a clean stream with random gaps.
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      step(0, 1, 0, 0);
      repeat ($urandom_range(1, 5)) step(0, 0, 0, 0);
    end

    // Three errors at the end of a window plus one at the start of the next: lock held.
    for (int i = 0; i < 300 && !(m_win == WIN - 3 && m_werr == 0); i++) step(0, 1, 0, 0);
    repeat (3) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    repeat (10) step(0, 1, 0, 0);

    // Four errors inside one window: lock lost on the fourth, relock 8 bits later.
    step(0, 0, 0, 1);
    for (int i = 0; i < 300 && !(m_win == 5 && m_werr == 0); i++) step(0, 1, 0, 0);
    repeat (3) begin
      step(0, 1, 1, 0);
      step(0, 1, 0, 0);
    end
    step(0, 1, 1, 0);
    repeat (28) step(0, 1, 0, 0);

    // Seven spaced errors, then clear coinciding with an error.
    step(0, 0, 0, 1);
    repeat (7) begin
      step(0, 1, 1, 0);
      repeat (29) step(0, 1, 0, 0);
    end
    step(0, 1, 1, 1);
    repeat (5) step(0, 1, 0, 0);

    // Zero run keeps SEARCH; the first one bit after the fill completes locks.
    step(1, 0, 0, 0);
    g = 8'h00;
    repeat (5) step(0, 1, 0, 0);
    g = 8'h01;
    repeat (48) step(0, 1, 0, 0);

    // Reset while locked with a pending error.
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    repeat (12) step(0, 1, 0, 0);
    @(negedge clk);
    compare_pop();
    en = 1'b0;

    // Long error runs on the 255/255 instance: 8 fill bits then 255 errors per loss cycle.
    @(negedge clk);
    rst2 = 1'b0;
    repeat (262) sat_bit();
    sat_pause();
    chk("sat_locked_262", {15'd0, locked2}, 16'd1);
    chk("sat_cnt_262", err_count2, ec(16'd254));
    sat_bit();
    sat_pause();
    chk("sat_locked_263", {15'd0, locked2}, 16'd0);
    chk("sat_pulse_263", {15'd0, err_pulse2}, 16'd1);
    chk("sat_cnt_263", err_count2, ec(16'd255));
`ifdef PRBS_CHK_ERRCNT_EN
    repeat (67590 - 263) sat_bit();
    sat_pause();
    chk("sat_cnt_65534", err_count2, 16'd65534);
    sat_bit();
    sat_pause();
    chk("sat_cnt_65535", err_count2, 16'hFFFF);
    repeat (200) sat_bit();
    sat_pause();
    chk("sat_cnt_hold", err_count2, 16'hFFFF);
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    chk("sat_clr", err_count2, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
